// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-cycle shift unit.
//   - fill / direction encodings for the la and lr request fields
//   - FSM state encoding
//   - shamt_w(): width of a shift-amount field for a given operand width
package shift_pkg;

    localparam logic SH_LOGIC = 1'b0;
    localparam logic SH_ARITH = 1'b1;
    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of bits needed to hold a shift amount of 0..xlen-1.
    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// shift_step: one combinational pass of the narrow shift stage.
// Ports:
//   data_i   operand
//   la_i     0 logical, 1 arithmetic (only meaningful for right shifts)
//   lr_i     0 left, 1 right
//   k_i      shift distance, 0..STEP inclusive
//   result_o shifted operand
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] data_i,
    input  logic            la_i,
    input  logic            lr_i,
    input  logic [KW-1:0]   k_i,
    output logic [XLEN-1:0] result_o
);

    // Select left, logical-right or sign-filling right shift.
    always_comb begin
        result_o = data_i;
        if (lr_i == SH_LEFT) begin
            result_o = data_i << k_i;
        end else if (la_i == SH_ARITH) begin
            result_o = $unsigned($signed(data_i) >>> k_i);
        end else begin
            result_o = data_i >> k_i;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter that moves at most STEP bits per cycle.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     request handshake; in_data, in_la, in_lr, in_shamt
//   flush                 synchronous abort, highest priority
//   out_valid/out_ready   result handshake; out_data is the accumulator register
//   busy                  high whenever the FSM is not IDLE
module shift_seq
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     in_la,
    input  logic                     in_lr,
    input  logic [shamt_w(XLEN)-1:0] in_shamt,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_data,
    output logic                     busy
);

    localparam int SW = shamt_w(XLEN);
    localparam int KW = $clog2(STEP + 1);
    // One extra bit so STEP itself is representable even when STEP == XLEN.
    localparam logic [SW:0] STEP_EXT = (SW + 1)'(STEP);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [SW-1:0]     remaining_q, remaining_d;
    logic              la_q, la_d;
    logic              lr_q, lr_d;

    logic [SW:0]       rem_ext_s;
    logic [KW-1:0]     k_s;
    logic              last_step_s;
    logic [XLEN-1:0]   step_result_s;

    // Per-cycle distance: min(remaining, STEP), never more than what is left.
    always_comb begin
        rem_ext_s = {1'b0, remaining_q};
        if (rem_ext_s < STEP_EXT) begin
            k_s = KW'(rem_ext_s);
        end else begin
            k_s = KW'(STEP_EXT);
        end
        last_step_s = (rem_ext_s <= STEP_EXT);
    end

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .data_i   (acc_q),
        .la_i     (la_q),
        .lr_i     (lr_q),
        .k_i      (k_s),
        .result_o (step_result_s)
    );

    // Next-state, datapath update and handshake outputs; flush overrides all.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        la_d        = la_q;
        lr_d        = lr_q;
        in_ready    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acc_d       = in_data;
                        la_d        = in_la;
                        lr_d        = in_lr;
                        remaining_d = in_shamt;
                        if (in_shamt == SW'(0)) begin
                            state_d = DONE;
                        end else begin
                            state_d = BUSY;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    acc_d       = step_result_s;
                    remaining_d = remaining_q - SW'(k_s);
                    if (last_step_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            la_q        <= 1'b0;
            lr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            la_q        <= la_d;
            lr_q        <= lr_d;
        end
    end

    // Outputs decode directly from registers.
    always_comb begin
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_data  = acc_q;
    end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_la;
    logic        in_lr;
    logic [4:0]  in_shamt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int errors;
    int checks;

    shift_seq #(.XLEN(32), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_la     (in_la),
        .in_lr     (in_lr),
        .in_shamt  (in_shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request at cycle T, measure latency to out_valid, check data, then drain.
    task automatic run_req(input string name, input logic [31:0] d, input logic la,
                           input logic lr, input logic [4:0] sh,
                           input logic [31:0] exp_d, input int exp_lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_la = la; in_lr = lr; in_shamt = sh;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready got=%b exp=1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== exp_lat) begin
            errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, n, exp_lat);
        end
        checks++;
        if (out_data !== exp_d) begin
            errors++; $display("FAIL %s_data got=%h exp=%h", name, out_data, exp_d);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_drain got=v%b r%b exp=v0 r1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_la = 1'b0; in_lr = 1'b0;
        in_shamt = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL reset got=v%b b%b d%h exp=v0 b0 d0", out_valid, busy, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_shifts();
        run_req("arith_r4",  32'h8000_00F0, 1'b1, 1'b1, 5'd4,  32'hF800_000F, 2);
        run_req("logic_r31", 32'h8000_0001, 1'b0, 1'b1, 5'd31, 32'h0000_0001, 9);
        run_req("arith_r31", 32'h8000_0001, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 9);
        run_req("left_la1",  32'h0000_0001, 1'b1, 1'b0, 5'd31, 32'h8000_0000, 9);
        run_req("left_la0",  32'h0000_0001, 1'b0, 1'b0, 5'd31, 32'h8000_0000, 9);
        run_req("logic_r5",  32'hF000_0000, 1'b0, 1'b1, 5'd5,  32'h0780_0000, 3);
        run_req("left_7",    32'h0000_00FF, 1'b0, 1'b0, 5'd7,  32'h0000_7F80, 3);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_la = 1'b0; in_lr = 1'b1; in_shamt = 5'd0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL zero_shift got=v%b d%h exp=v1 dDEADBEEF", out_valid, out_data);
        end
        // in_valid stays high: nothing may be accepted while DONE.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d got=v%b d%h r%b exp=v1 dDEADBEEF r0", i, out_valid, out_data, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL done_no_accept got=%b exp=0", in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL after_hs got=r%b v%b exp=r1 v0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h1234_5678; in_la = 1'b0; in_lr = 1'b0; in_shamt = 5'd20;
        @(negedge clk);  // T+1
        in_valid = 1'b0;
        @(negedge clk);  // T+2
        @(negedge clk);  // T+3
        flush = 1'b1;
        @(negedge clk);  // T+4
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_busy got=%b exp=0", busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL flush_outvalid got=%0d exp=0", seen);
        end
        in_valid = 1'b1; flush = 1'b1; in_shamt = 5'd3;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_idle_ready got=%b exp=0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle_accept got=b%b v%b exp=b0 v0", busy, out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hA5A5_A5A5; in_la = 1'b0; in_lr = 1'b0; in_shamt = 5'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL async_rst got=v%b b%b d%h exp=v0 b0 d0", out_valid, busy, out_data);
        end
        #2;
        rst_n = 1'b1;
        run_req("post_rst", 32'h0000_0F00, 1'b1, 1'b1, 5'd8, 32'h0000_000F, 3);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_shifts();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
